// File: rtl/pixel_array_adc.sv
// pixel_array_adc: N-pixel sensor array sharing one ramp ADC, with valid/ready pixel readout
module pixel_array_adc #(
    parameter int N_PIXELS   = 4,
    parameter int ADC_BITS   = 8,
    parameter int LIGHT_BITS = 4,
    parameter int EXP_BITS   = 8,
    parameter int IDX_BITS   = 2
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           START,
    input  logic [EXP_BITS-1:0]            EXPOSE_LEN,
    input  logic [N_PIXELS*LIGHT_BITS-1:0] LIGHT,
    output logic                           BUSY,
    output logic [ADC_BITS-1:0]            DATA,
    output logic [IDX_BITS-1:0]            DATA_IDX,
    output logic                           DATA_VALID,
    input  logic                           DATA_READY,
    output logic                           DONE
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READOUT = 3'd4;
    localparam logic [ADC_BITS-1:0] MAX = '1;

    logic [2:0]          state_q, state_d;
    logic [EXP_BITS-1:0] cnt_q, cnt_d;
    logic [ADC_BITS-1:0] ramp_q, ramp_d;
    logic [ADC_BITS-1:0] pix_q [N_PIXELS];
    logic [ADC_BITS-1:0] pix_d [N_PIXELS];
    logic [ADC_BITS-1:0] code_q [N_PIXELS];
    logic [ADC_BITS-1:0] code_d [N_PIXELS];
    logic [N_PIXELS-1:0] lat_q, lat_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    assign BUSY       = state_q != S_IDLE;
    assign DATA       = code_q[idx_q];
    assign DATA_IDX   = idx_q;
    assign DATA_VALID = valid_q;
    assign DONE       = done_q;

    // Frame sequencer: erase, integrate light, ramp-compare, then stream codes out
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ramp_d  = ramp_q;
        pix_d   = pix_q;
        code_d  = code_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = START ? S_ERASE : S_IDLE;
                cnt_d   = START ? EXPOSE_LEN : cnt_q;
            end
            S_ERASE: begin
                for (int i = 0; i < N_PIXELS; i++) begin
                    pix_d[i]  = MAX;
                    code_d[i] = '0;
                end
                lat_d   = '0;
                ramp_d  = '0;
                state_d = (cnt_q == '0) ? S_CONVERT : S_EXPOSE;
            end
            S_EXPOSE: begin
                for (int i = 0; i < N_PIXELS; i++)
                    pix_d[i] = (pix_q[i] > ADC_BITS'(LIGHT[i*LIGHT_BITS +: LIGHT_BITS]))
                             ? pix_q[i] - ADC_BITS'(LIGHT[i*LIGHT_BITS +: LIGHT_BITS]) : '0;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == EXP_BITS'(1)) ? S_CONVERT : S_EXPOSE;
            end
            S_CONVERT: begin
                for (int i = 0; i < N_PIXELS; i++)
                    if (!lat_q[i] && ramp_q >= pix_q[i]) begin
                        code_d[i] = ramp_q;
                        lat_d[i]  = 1'b1;
                    end
                ramp_d  = (ramp_q == MAX) ? '0 : ramp_q + 1'b1;
                state_d = (ramp_q == MAX) ? S_READOUT : S_CONVERT;
                valid_d = ramp_q == MAX;
                idx_d   = '0;
            end
            S_READOUT: begin
                if (DATA_READY) begin
                    if (idx_q == IDX_BITS'(N_PIXELS - 1)) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ramp_q  <= '0;
            pix_q   <= '{default: '0};
            code_q  <= '{default: '0};
            lat_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ramp_q  <= ramp_d;
            pix_q   <= pix_d;
            code_q  <= code_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
endmodule
